grace_rc_bank: RTL and testbench
================================

# grace_rc_bank

Multi-word read-to-clear status bank on the Grace slave interface, generalising the single-word read-clear register. It latches event bits from NREG status words, clears only the word that is read, and keeps per-word interrupt-enable masks writable over Grace. It raises a single interrupt whenever an enabled latched bit is set. It sits between peripheral event sources and the Grace bus decoder, one instance per status region.

## Interface
Parameters:
- DW, 32: Grace data width and bits per status word
- NREG, 4: number of status words, 1..16
- AW, 3: address width; must satisfy 2^AW >= 2*NREG
- IR, 0: 1 adds a two-flop input synchroniser on Reg_In; 0 uses Reg_In directly
- OR, 0: 1 adds an output register stage on Grace_RD and Grace_Ac
- EDGE, 0: 0 sets a bit on every cycle the input is high; 1 sets it only on a rising edge of the input

Ports:
- Grace_Ck  in  1  clock; the only clock
- Grace_Rs  in  1  reset, synchronous, active-high
- Grace_CS  in  1  chip select, held high for the whole access
- Grace_WR  in  1  1 = write, 0 = read; sampled at the CS rising edge
- Grace_Ad  in  AW  word address; sampled at the CS rising edge
- Grace_WD  in  DW  write data; sampled at the CS rising edge
- Grace_Re  out  1  ready; constant 1
- Grace_Ac  out  1  acknowledge
- Grace_RD  out  DW  read data
- Reg_In  in  NREG*DW  event inputs; word k is Reg_In[k*DW +: DW]
- Irq  out  1  interrupt, registered

## Operation
- Address map:
  - 0..NREG-1: status words, read-to-clear.
  - NREG..2*NREG-1: enable masks, read/write.
  - All other addresses: read returns 0; writes are ignored.
- Access start: detected as Grace_CS=1 with CS_R=0, where CS_R is the registered copy of Grace_CS. Exactly one access occurs per CS rising edge.
- Event path: in_s is Reg_In, or Reg_In after two flops when IR=1.
  - ev = in_s when EDGE=0.
  - ev = in_s & ~in_prev when EDGE=1; in_prev is a register of in_s.
- Latch update, per word k, every cycle: lat_k <= (lat_k & ~clr_k) | ev_k.
  - clr_k is all-ones only for a status read of word k at the access start; otherwise zero.
  - Set wins over clear: an event at the clearing edge stays latched and is not in the snapshot.
- Status read: at the access start, snap <= lat_k of the pre-edge value, and word k is cleared. Other words are untouched.
- Mask read: snap <= en_k. No side effects.
- Mask write: en_k <= Grace_WD at the access start. snap is unchanged. Status words are never altered by writes.
- Writes to status addresses: ignored.
- Irq <= OR over k of |(lat_k & en_k). A bit cleared by a read still drives Irq in the cycle it clears; Irq drops one cycle later.
- Grace_Re = 1 always.

## Timing
- Reset (synchronous, Grace_Rs=1 at an edge) zeroes the following, all effective after that edge:
  - all lat_k, all en_k, snap, CS_R, in_prev, the synchroniser flops, the ack pipeline, the RD output register, and Irq.
- Outputs after reset: Grace_Ac=0, Grace_RD=0, Irq=0.
- Reset mid-access: Ack drops after the reset edge. CS_R=0 after reset, so a Grace_CS still high when reset releases is treated as a new access at the first non-reset edge. Masters must deassert CS across reset.
- Ack: Grace_Ac is Grace_CS delayed by 1 edge (OR=0) or 2 edges (OR=1). It is a level, high while CS is held, and falls 1 or 2 edges after CS falls.
- Read data: Grace_RD = snap (OR=0), or snap registered (OR=1). It is valid whenever Grace_Ac=1 and holds until the next access start.
- Event-to-latch latency: 1 edge (IR=0) or 3 edges (IR=1). EDGE mode adds none.
- Latch to Irq: 1 additional edge.
- Back-to-back accesses need CS low for at least 1 edge between them.

## Test plan
- Reset, then idle: Grace_Ac=0, Grace_RD=0, Irq=0. Reading addresses 0..2*NREG-1 returns all zeros.
- Pulse Reg_In word 1 bit 5 for one cycle (IR=0, EDGE=0). Read address 1 -> RD=0x00000020 while Ac=1. Read address 1 again -> RD=0. Words 0, 2 and 3 are unchanged.
- Hold word 0 bit 0 high across a read of address 0 -> RD=0x1. The next read returns 0x1 again, because set wins over clear.
- EDGE=1: hold word 2 bit 3 high for 10 cycles. Read address 2 -> 0x8. Read again with the input still high -> 0.
- Write 0x00000100 to address NREG+3, then pulse word 3 bit 8 -> Irq=1 two edges after the pulse (IR=0). Read address 3 -> Irq=0 one edge after the clear. Read address NREG+3 -> RD=0x100. A write to address 2*NREG is ignored and still acked.
- OR=1, IR=1: Ack rises 2 edges after CS. The event-to-latch latency is 3 edges. Assert Grace_Rs with CS high -> Ac=0 and all registers zero on the next edge.

Source files
------------

// File: rtl/grace_rc_bank_if.sv
// grace_rc_bank_if: Grace slave bus signals between a bus decoder and a status bank
interface grace_rc_bank_if #(
  parameter int DW = 32,
  parameter int AW = 3
);
  logic          Grace_CS;
  logic          Grace_WR;
  logic [AW-1:0] Grace_Ad;
  logic [DW-1:0] Grace_WD;
  logic          Grace_Re;
  logic          Grace_Ac;
  logic [DW-1:0] Grace_RD;
  modport master (output Grace_CS, Grace_WR, Grace_Ad, Grace_WD, input Grace_Re, Grace_Ac, Grace_RD);
  modport slave  (input Grace_CS, Grace_WR, Grace_Ad, Grace_WD, output Grace_Re, Grace_Ac, Grace_RD);
endinterface

// File: rtl/grace_rc_bank.sv
// grace_rc_bank: multi-word read-to-clear status bank with per-word interrupt masks on the Grace bus
module grace_rc_bank #(
  parameter int DW   = 32,
  parameter int NREG = 4,
  parameter int AW   = 3,
  parameter int IR   = 0,
  parameter int OR   = 0,
  parameter int EDGE = 0
) (
  input  logic               Grace_Ck,
  input  logic               Grace_Rs,
  grace_rc_bank_if.slave     bus,
  input  logic [NREG*DW-1:0] Reg_In,
  output logic               Irq
);
  localparam int W = NREG * DW;
  logic          r_cs, r_irq, w_start, w_irq;
  logic [DW-1:0] r_lat [NREG];
  logic [DW-1:0] r_en [NREG];
  logic [DW-1:0] r_snap, w_rd;
  logic [W-1:0]  w_in, w_ev;
  logic [AW:0]   w_a;
  assign w_a = {1'b0, bus.Grace_Ad};
  assign w_start = bus.Grace_CS & ~r_cs;
  assign bus.Grace_Re = 1'b1;
  assign Irq = r_irq;
  if (IR != 0) begin : g_sync
    logic [W-1:0] r_s1, r_s2;
    always_ff @(posedge Grace_Ck) begin
      r_s1 <= Grace_Rs ? '0 : Reg_In;
      r_s2 <= Grace_Rs ? '0 : r_s1;
    end
    assign w_in = r_s2;
  end else begin : g_direct
    assign w_in = Reg_In;
  end
  if (EDGE != 0) begin : g_edge
    logic [W-1:0] r_prev;
    always_ff @(posedge Grace_Ck) r_prev <= Grace_Rs ? '0 : w_in;
    assign w_ev = w_in & ~r_prev;
  end else begin : g_level
    assign w_ev = w_in;
  end
  // r_cs doubles as the first ack stage: ack is CS delayed by one edge
  if (OR != 0) begin : g_oreg
    logic          r_ack2;
    logic [DW-1:0] r_rd;
    always_ff @(posedge Grace_Ck) begin
      r_ack2 <= Grace_Rs ? 1'b0 : r_cs;
      r_rd   <= Grace_Rs ? '0 : r_snap;
    end
    assign bus.Grace_Ac = r_ack2;
    assign bus.Grace_RD = r_rd;
  end else begin : g_comb
    assign bus.Grace_Ac = r_cs;
    assign bus.Grace_RD = r_snap;
  end
  always_comb begin
    w_rd = '0;
    w_irq = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      w_rd = (w_a == (AW+1)'(k)) ? r_lat[k] : (w_a == (AW+1)'(NREG + k)) ? r_en[k] : w_rd;
      w_irq = w_irq | (|(r_lat[k] & r_en[k]));
    end
  end
  // set wins over clear: an event on the clearing edge stays latched
  always_ff @(posedge Grace_Ck) begin
    if (Grace_Rs) begin
      r_cs   <= 1'b0;
      r_irq  <= 1'b0;
      r_snap <= '0;
      for (int k = 0; k < NREG; k++) begin
        r_lat[k] <= '0;
        r_en[k]  <= '0;
      end
    end else begin
      r_cs  <= bus.Grace_CS;
      r_irq <= w_irq;
      if (w_start && !bus.Grace_WR) r_snap <= w_rd;
      for (int k = 0; k < NREG; k++) begin
        r_lat[k] <= ((w_start && !bus.Grace_WR && w_a == (AW+1)'(k)) ? '0 : r_lat[k]) | w_ev[k*DW +: DW];
        if (w_start && bus.Grace_WR && w_a == (AW+1)'(NREG + k)) r_en[k] <= bus.Grace_WD;
      end
    end
  end
endmodule

// File: tb/tb_grace_rc_bank.sv
// tb_grace_rc_bank: two banks (plain, and synchronised/registered/edge) on one shared bus vs a behavioural model
module tb_grace_rc_bank;
  localparam int DW = 32, NREG = 4, AW = 4, W = NREG * DW;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cs = 0, wr = 0;
  logic [AW-1:0] ad = '0;
  logic [DW-1:0] wd = '0;
  logic [W-1:0] reg_in = '0;
  logic irq_a, irq_b;
  int errors = 0, checks = 0;
  grace_rc_bank_if #(.DW(DW), .AW(AW)) bus_a ();
  grace_rc_bank_if #(.DW(DW), .AW(AW)) bus_b ();
  assign bus_a.Grace_CS = cs;
  assign bus_a.Grace_WR = wr;
  assign bus_a.Grace_Ad = ad;
  assign bus_a.Grace_WD = wd;
  assign bus_b.Grace_CS = cs;
  assign bus_b.Grace_WR = wr;
  assign bus_b.Grace_Ad = ad;
  assign bus_b.Grace_WD = wd;
  grace_rc_bank #(.DW(DW), .NREG(NREG), .AW(AW)) dut_a (
    .Grace_Ck(clk), .Grace_Rs(rst), .bus(bus_a), .Reg_In(reg_in), .Irq(irq_a));
  grace_rc_bank #(.DW(DW), .NREG(NREG), .AW(AW), .IR(1), .OR(1), .EDGE(1)) dut_b (
    .Grace_Ck(clk), .Grace_Rs(rst), .bus(bus_b), .Reg_In(reg_in), .Irq(irq_b));
  // model: bank a sees the input directly; bank b sees it two cycles late, rising edges only
  logic [DW-1:0] ma [NREG];
  logic [DW-1:0] mb [NREG];
  logic [DW-1:0] men [NREG];
  logic [DW-1:0] ma_snap, mb_snap;
  logic [W-1:0] h1, h2, h3;
  logic m_csp, ma_irq, mb_irq, ma_any, mb_any, m_start;
  assign m_start = cs && !m_csp;
  always_comb begin
    ma_any = 1'b0;
    mb_any = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      ma_any = ma_any | (|(ma[k] & men[k]));
      mb_any = mb_any | (|(mb[k] & men[k]));
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        ma[k] <= '0;
        mb[k] <= '0;
        men[k] <= '0;
      end
      h1 <= '0; h2 <= '0; h3 <= '0;
      m_csp <= 1'b0; ma_irq <= 1'b0; mb_irq <= 1'b0;
      ma_snap <= '0; mb_snap <= '0;
    end else begin
      h1 <= reg_in; h2 <= h1; h3 <= h2;
      m_csp <= cs;
      ma_irq <= ma_any;
      mb_irq <= mb_any;
      for (int k = 0; k < NREG; k++) begin
        ma[k] <= ((m_start && !wr && int'(ad) == k) ? '0 : ma[k]) | reg_in[k*DW +: DW];
        mb[k] <= ((m_start && !wr && int'(ad) == k) ? '0 : mb[k]) | (h2[k*DW +: DW] & ~h3[k*DW +: DW]);
        if (m_start && wr && int'(ad) == NREG + k) men[k] <= wd;
      end
      if (m_start && !wr) begin
        ma_snap <= '0;
        mb_snap <= '0;
        for (int k = 0; k < NREG; k++) begin
          if (int'(ad) == k) begin
            ma_snap <= ma[k];
            mb_snap <= mb[k];
          end else if (int'(ad) == NREG + k) begin
            ma_snap <= men[k];
            mb_snap <= men[k];
          end
        end
      end
    end
  end
  task automatic access(input logic w, input int a, input logic [DW-1:0] d,
                        output logic [DW-1:0] ra, output logic [DW-1:0] rb);
    int n;
    @(negedge clk);
    cs = 1; wr = w; ad = AW'(a); wd = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus_a.Grace_Ac && bus_b.Grace_Ac) && n < 8);
    if (!(bus_a.Grace_Ac && bus_b.Grace_Ac)) begin
      errors++; checks++;
      $display("FAIL ack_timeout addr=%0d ac_a=%0b ac_b=%0b expected 1 1", a, bus_a.Grace_Ac, bus_b.Grace_Ac);
    end
    ra = bus_a.Grace_RD;
    rb = bus_b.Grace_RD;
    cs = 0; wr = 0;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset();
    logic [DW-1:0] ra, rb;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_a.Grace_Ac, bus_b.Grace_Ac, irq_a, irq_b, bus_a.Grace_Re, bus_b.Grace_Re} !== 6'b000011) begin
      errors++;
      $display("FAIL reset_ctrl ac/ac/irq/irq/re/re=%b expected 000011",
               {bus_a.Grace_Ac, bus_b.Grace_Ac, irq_a, irq_b, bus_a.Grace_Re, bus_b.Grace_Re});
    end
    checks++;
    if ({bus_a.Grace_RD, bus_b.Grace_RD} !== '0) begin
      errors++;
      $display("FAIL reset_rd a=%h b=%h expected 0", bus_a.Grace_RD, bus_b.Grace_RD);
    end
    rst = 0;
    for (int a = 0; a < 2 * NREG; a++) begin
      access(0, a, '0, ra, rb);
      checks++;
      if ({ra, rb} !== '0) begin
        errors++;
        $display("FAIL reset_read addr=%0d a=%h b=%h expected 0", a, ra, rb);
      end
    end
  endtask
  task automatic test_pulse();
    logic [DW-1:0] ra, rb;
    @(negedge clk); reg_in[1*DW + 5] = 1'b1;
    @(negedge clk); reg_in = '0;
    repeat (4) @(negedge clk);
    access(0, 1, '0, ra, rb);
    checks++;
    if (ra !== 32'h20 || rb !== 32'h20) begin
      errors++;
      $display("FAIL pulse_read a=%h b=%h expected 00000020", ra, rb);
    end
    access(0, 1, '0, ra, rb);
    checks++;
    if ({ra, rb} !== '0) begin
      errors++;
      $display("FAIL pulse_reread a=%h b=%h expected 0", ra, rb);
    end
    for (int a = 0; a < NREG; a++) begin
      if (a != 1) begin
        access(0, a, '0, ra, rb);
        checks++;
        if ({ra, rb} !== '0) begin
          errors++;
          $display("FAIL pulse_other addr=%0d a=%h b=%h expected 0", a, ra, rb);
        end
      end
    end
  endtask
  task automatic test_hold();
    logic [DW-1:0] ra, rb;
    @(negedge clk); reg_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    access(0, 0, '0, ra, rb);
    checks++;
    if (ra !== 32'h1 || rb !== 32'h1) begin
      errors++;
      $display("FAIL hold_read a=%h b=%h expected 1 1", ra, rb);
    end
    access(0, 0, '0, ra, rb);
    checks++;
    if (ra !== 32'h1 || rb !== 32'h0) begin
      errors++;
      $display("FAIL hold_set_wins a=%h b=%h expected 1 0", ra, rb);
    end
    reg_in = '0;
    repeat (4) @(negedge clk);
    access(0, 0, '0, ra, rb);
    checks++;
    if (ra !== ma_snap || rb !== mb_snap) begin
      errors++;
      $display("FAIL hold_drain a=%h b=%h expected %h %h", ra, rb, ma_snap, mb_snap);
    end
  endtask
  task automatic test_edge();
    logic [DW-1:0] ra, rb;
    @(negedge clk); reg_in[2*DW + 3] = 1'b1;
    repeat (10) @(negedge clk);
    access(0, 2, '0, ra, rb);
    checks++;
    if (ra !== 32'h8 || rb !== 32'h8) begin
      errors++;
      $display("FAIL edge_read a=%h b=%h expected 8 8", ra, rb);
    end
    access(0, 2, '0, ra, rb);
    checks++;
    if (ra !== 32'h8 || rb !== 32'h0) begin
      errors++;
      $display("FAIL edge_held a=%h b=%h expected 8 0", ra, rb);
    end
    reg_in = '0;
    repeat (4) @(negedge clk);
    access(0, 2, '0, ra, rb);
    checks++;
    if (ra !== ma_snap || rb !== mb_snap) begin
      errors++;
      $display("FAIL edge_drain a=%h b=%h expected %h %h", ra, rb, ma_snap, mb_snap);
    end
  endtask
  task automatic test_ack();
    logic [3:0] seen;
    @(negedge clk); cs = 1; wr = 0; ad = AW'(NREG);
    @(negedge clk); seen[3:2] = {bus_a.Grace_Ac, bus_b.Grace_Ac};
    @(negedge clk); seen[1:0] = {bus_a.Grace_Ac, bus_b.Grace_Ac};
    checks++;
    if (seen !== 4'b1011) begin
      errors++;
      $display("FAIL ack_rise a,b per edge=%b expected 1011", seen);
    end
    cs = 0;
    @(negedge clk); seen[3:2] = {bus_a.Grace_Ac, bus_b.Grace_Ac};
    @(negedge clk); seen[1:0] = {bus_a.Grace_Ac, bus_b.Grace_Ac};
    checks++;
    if (seen !== 4'b0100) begin
      errors++;
      $display("FAIL ack_fall a,b per edge=%b expected 0100", seen);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_irq();
    logic [DW-1:0] ra, rb;
    logic [7:0] seen;
    access(1, NREG + 3, 32'h100, ra, rb);
    checks++;
    if ({irq_a, irq_b} !== 2'b00) begin
      errors++;
      $display("FAIL irq_idle a=%b b=%b expected 0 0", irq_a, irq_b);
    end
    @(negedge clk); reg_in[3*DW + 8] = 1'b1;
    @(negedge clk); reg_in = '0; seen[7:6] = {irq_a, irq_b};
    @(negedge clk); seen[5:4] = {irq_a, irq_b};
    @(negedge clk); seen[3:2] = {irq_a, irq_b};
    @(negedge clk); seen[1:0] = {irq_a, irq_b};
    checks++;
    if (seen !== 8'b00101011) begin
      errors++;
      $display("FAIL irq_latency a,b per edge=%b expected 00101011", seen);
    end
    cs = 1; wr = 0; ad = AW'(3);
    @(negedge clk); seen[1:0] = {irq_a, irq_b};
    checks++;
    if (seen[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL irq_clear_edge a=%b b=%b expected 1 1", seen[1], seen[0]);
    end
    @(negedge clk);
    checks++;
    if ({irq_a, irq_b} !== 2'b00 || bus_a.Grace_RD !== 32'h100 || bus_b.Grace_RD !== 32'h100) begin
      errors++;
      $display("FAIL irq_drop irq=%b%b rd_a=%h rd_b=%h expected 00 100 100", irq_a, irq_b, bus_a.Grace_RD, bus_b.Grace_RD);
    end
    cs = 0;
    repeat (3) @(negedge clk);
    access(0, NREG + 3, '0, ra, rb);
    checks++;
    if (ra !== 32'h100 || rb !== 32'h100) begin
      errors++;
      $display("FAIL mask_read a=%h b=%h expected 100", ra, rb);
    end
    access(1, 2 * NREG, 32'hFFFF_FFFF, ra, rb);
    access(0, 2 * NREG, '0, ra, rb);
    checks++;
    if ({ra, rb} !== '0) begin
      errors++;
      $display("FAIL unmapped_read a=%h b=%h expected 0", ra, rb);
    end
    access(0, NREG + 3, '0, ra, rb);
    checks++;
    if (ra !== 32'h100 || rb !== 32'h100) begin
      errors++;
      $display("FAIL mask_after_unmapped a=%h b=%h expected 100", ra, rb);
    end
  endtask
  task automatic test_reset_mid();
    logic [DW-1:0] ra, rb;
    @(negedge clk); reg_in[3*DW + 8] = 1'b1;
    @(negedge clk); reg_in = '0;
    repeat (5) @(negedge clk);
    checks++;
    if ({irq_a, irq_b} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_pre irq a=%b b=%b expected 1 1", irq_a, irq_b);
    end
    cs = 1; wr = 0; ad = AW'(NREG + 3);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({bus_a.Grace_Ac, bus_b.Grace_Ac, irq_a, irq_b} !== 4'b0000 || {bus_a.Grace_RD, bus_b.Grace_RD} !== '0) begin
      errors++;
      $display("FAIL rstmid_outs ac=%b%b irq=%b%b rd_a=%h rd_b=%h expected 0", bus_a.Grace_Ac, bus_b.Grace_Ac,
               irq_a, irq_b, bus_a.Grace_RD, bus_b.Grace_RD);
    end
    cs = 0;
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    access(0, NREG + 3, '0, ra, rb);
    checks++;
    if ({ra, rb} !== '0) begin
      errors++;
      $display("FAIL rstmid_mask a=%h b=%h expected 0", ra, rb);
    end
    access(0, 3, '0, ra, rb);
    checks++;
    if ({ra, rb} !== '0) begin
      errors++;
      $display("FAIL rstmid_status a=%h b=%h expected 0", ra, rb);
    end
  endtask
  task automatic test_random();
    logic [DW-1:0] ra, rb;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      reg_in[$urandom_range(W - 1, 0)] = 1'b1;
      reg_in[$urandom_range(W - 1, 0)] = 1'b1;
      @(negedge clk); reg_in = '0;
      access(1'($urandom_range(1, 0)), int'($urandom_range(15, 0)), DW'($urandom), ra, rb);
      checks++;
      if (ra !== ma_snap || rb !== mb_snap) begin
        errors++;
        $display("FAIL rand_rd iter=%0d a=%h b=%h expected %h %h", i, ra, rb, ma_snap, mb_snap);
      end
      checks++;
      if ({irq_a, irq_b} !== {ma_irq, mb_irq}) begin
        errors++;
        $display("FAIL rand_irq iter=%0d a=%b b=%b expected %b %b", i, irq_a, irq_b, ma_irq, mb_irq);
      end
    end
  endtask
  initial begin
    test_reset();
    test_pulse();
    test_hold();
    test_edge();
    test_ack();
    test_irq();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
